// File: rtl/serial_comp_pkg.sv
// Shared types and helpers for the MSB-first serial magnitude comparator.
package serial_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Bit-counter width; cnt only ever holds WIDTH-1 down to 0.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_comp_bit_decide.sv
// Per-bit-pair greater/less decision cell for the serial comparator.
module bit_decide (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/serial_comp.sv
// Serial MSB-first comparator of two WIDTH-bit operands fed one bit pair per accept.
// Optional macro SERIAL_COMP_EARLY_EXIT_EN: finish as soon as the first differing pair is seen.
module serial_comp
  import serial_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic a_big,
  output logic b_big
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          decided;
  logic          decided_nxt;
  logic          a_big_nxt;
  logic          b_big_nxt;
  logic          done_nxt;
  logic          busy_nxt;
  logic          ready_nxt;
  logic          gt_c;
  logic          lt_c;
  logic          accept_c;

  bit_decide u_bit_decide (
    .a  (a_bit),
    .b  (b_bit),
    .gt (gt_c),
    .lt (lt_c)
  );

  // bit_ready is high exactly while in SHIFT, so it doubles as the state qualifier.
  assign accept_c = bit_valid && bit_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    decided_nxt = decided;
    a_big_nxt   = a_big;
    b_big_nxt   = b_big;
    done_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    ready_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          cnt_nxt     = CW'(WIDTH - 1);
          decided_nxt = 1'b0;
          a_big_nxt   = 1'b0;
          b_big_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (accept_c) begin
          // First differing pair from the MSB side fixes the result.
          if (!decided) begin
            a_big_nxt   = gt_c;
            b_big_nxt   = lt_c;
            decided_nxt = gt_c | lt_c;
          end
          cnt_nxt = (cnt == '0) ? cnt : cnt - CW'(1);
          if (cnt == '0) begin
            state_nxt = FIN;
          end
`ifdef SERIAL_COMP_EARLY_EXIT_EN
          if (!decided && (gt_c || lt_c)) begin
            state_nxt = FIN;
          end
`endif
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Handshake outputs are registered from the state being entered.
    busy_nxt  = (state_nxt == SHIFT);
    ready_nxt = (state_nxt == SHIFT);
    done_nxt  = (state_nxt == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      decided   <= 1'b0;
      a_big     <= 1'b0;
      b_big     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bit_ready <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      decided   <= decided_nxt;
      a_big     <= a_big_nxt;
      b_big     <= b_big_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      bit_ready <= ready_nxt;
    end
  end

endmodule

// File: doc/serial_comp.md
SERIAL_COMP -- requirements
Module: serial_comp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which is the operand length in bits and must be at least 2.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide: a one-cycle pulse that begins a comparison.
REQ-005 Port bit_valid SHALL be an input, 1 bit wide: a_bit and b_bit are valid this cycle.
REQ-006 Ports a_bit and b_bit SHALL be inputs, 1 bit wide each: operand bits, presented MSB first.
REQ-007 Port bit_ready SHALL be an output, 1 bit wide: the block accepts a bit pair this cycle.
REQ-008 Port busy SHALL be an output, 1 bit wide: a comparison is in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: a one-cycle pulse that marks the result as valid.
REQ-010 Ports a_big and b_big SHALL be outputs, 1 bit wide each: registered result flags, held until the next start.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and FIN.
REQ-012 IDLE SHALL go to SHIFT on start; in the same edge it clears a_big/b_big, clears the decided flag and loads bit counter cnt=WIDTH-1.
REQ-013 In SHIFT the block SHALL hold bit_ready=1 and busy=1; a bit pair is accepted only when bit_valid && bit_ready.
REQ-014 While undecided, an accepted pair SHALL set a_big on a_bit=1,b_bit=0 and b_big on a_bit=0,b_bit=1; equal bits change nothing.
REQ-015 Once a_big or b_big is set (decided), later bits SHALL NOT change the flags.
REQ-016 The block SHALL decrement cnt by 1 per accepted pair; the accept at cnt==0 moves the FSM to FIN.
REQ-017 In FIN the block SHALL assert done for exactly one cycle, with bit_ready=0 and busy=0, then return to IDLE.
REQ-018 Equal operands SHALL complete with a_big=0 and b_big=0; a_big and b_big SHALL never both be 1.
REQ-019 Latency SHALL be the result flags valid and done high one cycle after the final accepted pair; with continuous bit_valid, the total is WIDTH+1 cycles from the cycle after start.
REQ-020 A start during SHIFT or FIN SHALL be ignored.
REQ-021 A start in the same cycle as the done pulse SHALL be ignored.
REQ-022 A cycle with bit_valid=0 SHALL stall with no state change; there is no timeout.
REQ-023 In IDLE the block SHALL keep bit_ready=0 and SHALL ignore bit_valid.

Reset
REQ-024 On rst_n=0 the block SHALL asynchronously force state=IDLE, cnt=0, decided=0, a_big=0, b_big=0, done=0, busy=0 and bit_ready=0.
REQ-025 Reset asserted mid-comparison SHALL discard partial results; after release the block waits in IDLE for a new start.
REQ-026 Reset deassertion SHALL take effect at the next rising clk edge.

Configuration
REQ-027 The macro SERIAL_COMP_EARLY_EXIT_EN SHALL, when defined, make the first deciding pair move the FSM directly to FIN; done follows one cycle later and the remaining bits are not consumed (the producer observes bit_ready=0).
REQ-028 When SERIAL_COMP_EARLY_EXIT_EN is not defined, the block SHALL always consume exactly WIDTH pairs.
REQ-029 With the macro defined, equal operands SHALL still consume WIDTH pairs.

Structure
REQ-030 The shared package serial_comp_pkg SHALL contain the state enum type (IDLE, SHIFT, FIN) and the function computing counter width, $clog2(WIDTH).
REQ-031 The block SHALL contain one sub-module, bit_decide: a combinational per-bit greater/less cell (a, b -> gt, lt).
REQ-032 The FSM and the registers SHALL reside in serial_comp.

Verification (WIDTH=8)
REQ-033 Send A=0xA5, B=0xA4 continuously -> a_big=1, b_big=0, done on the 9th cycle after start.
REQ-034 Send A=0x3C, B=0x3C -> a_big=0, b_big=0, 8 pairs consumed.
REQ-035 Send A=0x12, B=0x80 with EARLY_EXIT_EN -> b_big=1 after 1 pair, bit_ready falls, done next cycle; without the macro -> b_big=1 after 8 pairs.
REQ-036 Send A=0xF0, B=0x0F with bit_valid toggled every other cycle -> a_big=1, 8 accepts, done one cycle after the 8th.
REQ-037 Assert rst_n=0 after 4 pairs -> all outputs 0 immediately; a new start with A=0x01, B=0x02 -> b_big=1.
REQ-038 Pulse start during SHIFT and again coincident with done -> both ignored; the results are unchanged.
